vote_session_arbiter: RTL and testbench

Session controller and shared-tally arbiter for the weighted voting datapath.
- Four ballot stations submit votes through req/ack handshakes.
- A round-robin arbiter grants at most one vote per cycle into a single dedup bitmap (32 normal, 8 VIP, 1 VVIP) and two 8-bit candidate tallies.
- An open/close session FSM sequences the whole session and produces a registered winner when the session closes.

---
 rtl/vote_session_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_vote_session_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_session_arbiter.sv
// Session controller and shared-tally arbiter for the weighted voting datapath.
// Four ballot stations compete round-robin for one grant per cycle. Each grant
// is classified as counted, duplicate or invalid against a dedup bitmap
// (32 normal, 8 VIP, 1 VVIP). Counted votes add their class weight to
// candidate A or B with saturation. An open/close FSM brackets the session and
// registers the winner on entry to DONE.
module vote_session_arbiter #(
  parameter int unsigned W_NP   = 1,
  parameter int unsigned W_VIP  = 4,
  parameter int unsigned W_VVIP = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [3:0]  req,
  input  logic [7:0]  cls,
  input  logic [19:0] idx,
  input  logic [3:0]  cand,
  output logic [3:0]  ack,
  output logic [1:0]  ack_status,
  output logic [7:0]  tally_a,
  output logic [7:0]  tally_b,
  output logic [1:0]  winner,
  output logic        done,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_OPEN    = 2'b01,
    S_CLOSING = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  localparam logic [1:0] ST_COUNTED   = 2'b00;
  localparam logic [1:0] ST_DUPLICATE = 2'b01;
  localparam logic [1:0] ST_INVALID   = 2'b10;

  // Weights wider than the tally clamp to full scale; the adders saturate anyway.
  localparam logic [7:0] W_NP8   = (W_NP   > 255) ? 8'hFF : 8'(W_NP);
  localparam logic [7:0] W_VIP8  = (W_VIP  > 255) ? 8'hFF : 8'(W_VIP);
  localparam logic [7:0] W_VVIP8 = (W_VVIP > 255) ? 8'hFF : 8'(W_VVIP);

  state_t      state_q;
  logic [3:0]  ack_q;
  logic [1:0]  ack_status_q;
  logic [7:0]  tally_a_q, tally_b_q;
  logic [1:0]  winner_q;
  logic        done_q;
  logic [1:0]  ptr_q;
  logic [31:0] bm_np_q;
  logic [7:0]  bm_vip_q;
  logic        bm_vvip_q;

  // Per-station classification, evaluated for all stations in parallel so the
  // grant mux only has to pick one result.
  logic [3:0] st_invalid;
  logic [3:0] st_dup;
  logic [7:0] st_weight [4];
  logic [1:0] st_cls    [4];
  logic [4:0] st_idx    [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_station
    assign st_cls[gi] = cls[2*gi+1:2*gi];
    assign st_idx[gi] = idx[5*gi+4:5*gi];
    assign st_invalid[gi] = (st_cls[gi] == 2'b11)
                          | ((st_cls[gi] == 2'b01) & (st_idx[gi] > 5'd7))
                          | ((st_cls[gi] == 2'b10) & (st_idx[gi] != 5'd0));
    assign st_dup[gi] = (st_cls[gi] == 2'b00) ? bm_np_q[st_idx[gi]] :
                        (st_cls[gi] == 2'b01) ? bm_vip_q[st_idx[gi][2:0]] :
                                                bm_vvip_q;
    assign st_weight[gi] = (st_cls[gi] == 2'b01) ? W_VIP8 :
                           (st_cls[gi] == 2'b10) ? W_VVIP8 : W_NP8;
  end

  // A station whose ack is showing this cycle is masked so a still-high req
  // cannot be granted twice for the same vote.
  logic [3:0] elig;
  assign elig = req & ~ack_q;

  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [1:0] rr_s;

  // Round-robin pick: first eligible station starting from ptr_q.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    rr_s        = 2'd0;
    if (state_q == S_OPEN && !stop) begin
      for (int k = 0; k < 4; k++) begin
        rr_s = ptr_q + 2'(k);
        if (!grant_valid && elig[rr_s]) begin
          grant_valid = 1'b1;
          grant_idx   = rr_s;
        end
      end
    end
  end

  logic [1:0] g_cls;
  logic [4:0] g_idx;
  logic       g_cand;
  logic       g_invalid, g_dup;
  logic [7:0] g_weight;
  logic [8:0] sum_a, sum_b;
  logic [7:0] tally_a_d, tally_b_d;

  assign g_cls     = st_cls[grant_idx];
  assign g_idx     = st_idx[grant_idx];
  assign g_cand    = cand[grant_idx];
  assign g_invalid = st_invalid[grant_idx];
  assign g_dup     = st_dup[grant_idx];
  assign g_weight  = st_weight[grant_idx];

  // Saturating candidate adders; the carry-out of the 9-bit sum pins at 255.
  always_comb begin
    sum_a     = {1'b0, tally_a_q} + {1'b0, g_weight};
    sum_b     = {1'b0, tally_b_q} + {1'b0, g_weight};
    tally_a_d = sum_a[8] ? 8'hFF : sum_a[7:0];
    tally_b_d = sum_b[8] ? 8'hFF : sum_b[7:0];
  end

  // Session FSM with registered grant, tally, bitmap and winner updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ack_q        <= 4'd0;
      ack_status_q <= 2'b00;
      tally_a_q    <= 8'd0;
      tally_b_q    <= 8'd0;
      winner_q     <= 2'b00;
      done_q       <= 1'b0;
      ptr_q        <= 2'd0;
      bm_np_q      <= 32'd0;
      bm_vip_q     <= 8'd0;
      bm_vvip_q    <= 1'b0;
    end else begin
      ack_q        <= 4'd0;
      ack_status_q <= 2'b00;
      case (state_q)
        S_IDLE, S_DONE: begin
          // A new session starts from clean tallies and bitmaps; ptr carries over.
          if (start) begin
            state_q   <= S_OPEN;
            done_q    <= 1'b0;
            winner_q  <= 2'b00;
            tally_a_q <= 8'd0;
            tally_b_q <= 8'd0;
            bm_np_q   <= 32'd0;
            bm_vip_q  <= 8'd0;
            bm_vvip_q <= 1'b0;
          end
        end
        S_OPEN: begin
          if (stop) begin
            state_q <= S_CLOSING;
          end else if (grant_valid) begin
            ack_q[grant_idx] <= 1'b1;
            ptr_q            <= grant_idx + 2'd1;
            if (g_invalid) begin
              ack_status_q <= ST_INVALID;
            end else if (g_dup) begin
              ack_status_q <= ST_DUPLICATE;
            end else begin
              ack_status_q <= ST_COUNTED;
              case (g_cls)
                2'b00:   bm_np_q[g_idx]       <= 1'b1;
                2'b01:   bm_vip_q[g_idx[2:0]] <= 1'b1;
                default: bm_vvip_q            <= 1'b1;
              endcase
              if (g_cand) tally_b_q <= tally_b_d;
              else        tally_a_q <= tally_a_d;
            end
          end
        end
        default: begin
          // CLOSING: one idle cycle, then latch the result.
          state_q  <= S_DONE;
          done_q   <= 1'b1;
          winner_q <= (tally_a_q > tally_b_q) ? 2'b01 :
                      (tally_b_q > tally_a_q) ? 2'b10 : 2'b11;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign ack_status = ack_status_q;
  assign tally_a    = tally_a_q;
  assign tally_b    = tally_b_q;
  assign winner     = winner_q;
  assign done       = done_q;
  assign state      = state_q;

endmodule

// File: tb/tb_vote_session_arbiter.sv
// Directed bench for vote_session_arbiter: a table of single votes with
// hand-computed status and tallies, plus hand-written multi-cycle sequences
// for round-robin order, ack masking, session close/reopen and async reset.
module tb_vote_session_arbiter;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [3:0]  req, cand;
  logic [7:0]  cls;
  logic [19:0] idx;
  logic [3:0]  ack;
  logic [1:0]  ack_status;
  logic [7:0]  tally_a, tally_b;
  logic [1:0]  winner;
  logic        done;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  vote_session_arbiter dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .req(req), .cls(cls), .idx(idx), .cand(cand),
    .ack(ack), .ack_status(ack_status),
    .tally_a(tally_a), .tally_b(tally_b),
    .winner(winner), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int         st;
    logic [1:0] c;
    logic [4:0] ix;
    logic       cd;
    logic [1:0] es;
    logic [7:0] ea;
    logic [7:0] eb;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Raise one station's request at a falling edge, wait for its ack, drop it.
  task automatic vote(input int st, input logic [1:0] c, input logic [4:0] ix,
                      input logic cd, output logic [3:0] a, output logic [1:0] s);
    int n;
    req[st]        = 1'b1;
    cls[2*st +: 2] = c;
    idx[5*st +: 5] = ix;
    cand[st]       = cd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 4'd0 && n < 20);
    a = ack;
    s = ack_status;
    req[st] = 1'b0;
    if (ack == 4'd0) begin
      n_checks++;
      n_fail++;
      $display("FAIL vote_timeout: station %0d got no ack", st);
    end
    $display("vote st=%0d cls=%b idx=%0d cand=%0d ack=%b status=%b ta=%0d tb=%0d",
             st, c, ix, cd, a, s, tally_a, tally_b);
  endtask

  task automatic vote_chk(input string nm, input int st, input logic [1:0] c,
                          input logic [4:0] ix, input logic cd, input logic [1:0] es);
    logic [3:0] a;
    logic [1:0] s;
    vote(st, c, ix, cd, a, s);
    chk({nm, "_ack"}, 32'(a), 32'(1 << st));
    chk({nm, "_status"}, 32'(s), 32'(es));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Close the session and check CLOSING lasts one cycle before DONE.
  task automatic do_stop(input string nm, input logic [1:0] exp_win);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk({nm, "_closing"}, 32'(state), 32'd2);
    chk({nm, "_closing_done"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({nm, "_done_state"}, 32'(state), 32'd3);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_winner"}, 32'(winner), 32'(exp_win));
    $display("close %s state=%0d done=%0d winner=%b ta=%0d tb=%0d",
             nm, state, done, winner, tally_a, tally_b);
  endtask

  initial begin
    logic [3:0] a;
    logic [1:0] s;
    int n;

    // st, cls, idx, cand, status, tally_a, tally_b
    tbl[0]  = '{0, 2'b00, 5'd5,  1'b0, 2'b00, 8'd1, 8'd0};   // normal idx5 A
    tbl[1]  = '{1, 2'b00, 5'd5,  1'b1, 2'b01, 8'd1, 8'd0};   // same voter, dup
    tbl[2]  = '{2, 2'b11, 5'd0,  1'b0, 2'b10, 8'd1, 8'd0};   // class 11
    tbl[3]  = '{3, 2'b01, 5'd9,  1'b0, 2'b10, 8'd1, 8'd0};   // VIP idx9
    tbl[4]  = '{0, 2'b10, 5'd1,  1'b1, 2'b10, 8'd1, 8'd0};   // VVIP idx1
    tbl[5]  = '{1, 2'b01, 5'd7,  1'b1, 2'b00, 8'd1, 8'd4};   // VIP idx7 B
    tbl[6]  = '{2, 2'b10, 5'd0,  1'b1, 2'b00, 8'd1, 8'd20};  // VVIP B
    tbl[7]  = '{3, 2'b10, 5'd0,  1'b0, 2'b01, 8'd1, 8'd20};  // VVIP again, dup
    tbl[8]  = '{0, 2'b00, 5'd31, 1'b0, 2'b00, 8'd2, 8'd20};  // normal idx31 A
    tbl[9]  = '{1, 2'b01, 5'd0,  1'b0, 2'b00, 8'd6, 8'd20};  // VIP idx0 A
    tbl[10] = '{2, 2'b00, 5'd5,  1'b0, 2'b01, 8'd6, 8'd20};  // idx5 dup again

    reset = 1'b1; start = 1'b0; stop = 1'b0;
    req = 4'd0; cls = 8'd0; idx = 20'd0; cand = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_status", 32'(ack_status), 32'd0);
    chk("rst_tally_a", 32'(tally_a), 32'd0);
    chk("rst_tally_b", 32'(tally_b), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // stop in IDLE does nothing
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle_stop", 32'(state), 32'd0);

    do_start();
    chk("open_state", 32'(state), 32'd1);

    // Table: counted / duplicate / invalid votes
    for (int i = 0; i < 11; i++) begin
      vote(tbl[i].st, tbl[i].c, tbl[i].ix, tbl[i].cd, a, s);
      chk($sformatf("vec%0d_ack", i), 32'(a), 32'(1 << tbl[i].st));
      chk($sformatf("vec%0d_status", i), 32'(s), 32'(tbl[i].es));
      chk($sformatf("vec%0d_tally_a", i), 32'(tally_a), 32'(tbl[i].ea));
      chk($sformatf("vec%0d_tally_b", i), 32'(tally_b), 32'(tbl[i].eb));
    end
    do_stop("tbl", 2'b10);

    // DONE ignores req and stop
    req[0] = 1'b1; cls[1:0] = 2'b00; idx[4:0] = 5'd9; cand[0] = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    chk("done_req_ack", 32'(ack), 32'd0);
    chk("done_stop_state", 32'(state), 32'd3);
    req[0] = 1'b0;

    // Full session: 32 normal + 8 VIP to A, VVIP to B
    do_start();
    chk("reopen_state", 32'(state), 32'd1);
    chk("reopen_tally_a", 32'(tally_a), 32'd0);
    chk("reopen_tally_b", 32'(tally_b), 32'd0);
    chk("reopen_winner", 32'(winner), 32'd0);
    for (int i = 0; i < 32; i++)
      vote_chk($sformatf("np%0d", i), i % 4, 2'b00, 5'(i), 1'b0, 2'b00);
    chk("full_np_tally_a", 32'(tally_a), 32'd32);
    for (int i = 0; i < 8; i++)
      vote_chk($sformatf("vip%0d", i), i % 4, 2'b01, 5'(i), 1'b0, 2'b00);
    vote_chk("vvip_b", 3, 2'b10, 5'd0, 1'b1, 2'b00);
    chk("full_tally_a", 32'(tally_a), 32'd64);
    chk("full_tally_b", 32'(tally_b), 32'd16);
    do_stop("full", 2'b01);

    // Tie: VVIP to A (reused voter counts again), 16 normal to B
    do_start();
    chk("tie_open_tally_a", 32'(tally_a), 32'd0);
    vote_chk("tie_vvip", 0, 2'b10, 5'd0, 1'b0, 2'b00);
    chk("tie_vvip_tally_a", 32'(tally_a), 32'd16);
    for (int i = 0; i < 16; i++)
      vote_chk($sformatf("tie_np%0d", i), (i + 1) % 4, 2'b00, 5'(i), 1'b1, 2'b00);
    chk("tie_tally_b", 32'(tally_b), 32'd16);
    // A request raised together with stop is never acknowledged
    req[2] = 1'b1; cls[5:4] = 2'b00; idx[14:10] = 5'd20; cand[2] = 1'b1;
    do_stop("tie", 2'b11);
    chk("pending_ack_closed", 32'(ack), 32'd0);
    chk("pending_tally_b", 32'(tally_b), 32'd16);
    @(negedge clk);
    chk("pending_ack_done", 32'(ack), 32'd0);
    req[2] = 1'b0;

    // start together with stop in OPEN -> stop wins
    do_start();
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("startstop_state", 32'(state), 32'd2);
    @(negedge clk);
    chk("startstop_done", 32'(state), 32'd3);

    // Reset while an ack is showing
    do_start();
    req[1] = 1'b1; cls[3:2] = 2'b10; idx[9:5] = 5'd0; cand[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 4'd0 && n < 20);
    chk("prerst_ack", 32'(ack), 32'd2);
    chk("prerst_tally_b", 32'(tally_b), 32'd16);
    reset = 1'b1;
    #1;
    chk("asyncrst_ack", 32'(ack), 32'd0);
    chk("asyncrst_state", 32'(state), 32'd0);
    chk("asyncrst_tally_b", 32'(tally_b), 32'd0);
    $display("async reset ack=%b state=%0d tb=%0d", ack, state, tally_b);
    req = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Round robin from ptr=0, all four VIP idx0..3 to A
    do_start();
    cls = 8'b01_01_01_01;
    idx = {5'd3, 5'd2, 5'd1, 5'd0};
    cand = 4'd0;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_ack", k), 32'(ack), 32'(1 << k));
      chk($sformatf("rr%0d_status", k), 32'(ack_status), 32'd0);
      $display("rr step %0d ack=%b ta=%0d", k, ack, tally_a);
      req = req & ~ack;
    end
    chk("rr_tally_a", 32'(tally_a), 32'd16);
    @(negedge clk);
    chk("rr_no_repeat", 32'(ack), 32'd0);

    // Station keeps req high through its ack cycle: no second grant
    cls[1:0] = 2'b00; idx[4:0] = 5'd3; cand[0] = 1'b0;
    req[0] = 1'b1;
    @(negedge clk);
    chk("mask_ack", 32'(ack), 32'd1);
    @(negedge clk);
    chk("mask_hold_ack", 32'(ack), 32'd0);
    req[0] = 1'b0;
    chk("mask_tally_a", 32'(tally_a), 32'd17);
    $display("mask ack=%b ta=%0d", ack, tally_a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
